// File: rtl/packet_buffer_read_arbiter_if.sv
// Bundle of request, BRAM read-driver and return-data signals for the packet-buffer read arbiter.
// The arbiter uses the slave modport; the environment (requesters + driver) uses master.
interface packet_buffer_read_arbiter_if #(
   parameter int unsigned RAM_SIZE = 64,
   parameter int unsigned BYTE_LEN = 8
);
   localparam int unsigned ADDR_W = $clog2(RAM_SIZE);

   logic [1:0]          req_valid;
   logic [ADDR_W-1:0]   req_addr0;
   logic [ADDR_W-1:0]   req_addr1;
   logic [ADDR_W:0]     req_len0;
   logic [ADDR_W:0]     req_len1;
   logic [1:0]          req_ready;
   logic                rd_req;
   logic [ADDR_W-1:0]   rd_addr;
   logic                rd_ready;
   logic [BYTE_LEN-1:0] rd_data;
   logic [1:0]          out_valid;
   logic [BYTE_LEN-1:0] out_data;
   logic                out_last;
   logic                busy;

   modport slave (
      input  req_valid, req_addr0, req_addr1, req_len0, req_len1, rd_ready, rd_data,
      output req_ready, rd_req, rd_addr, out_valid, out_data, out_last, busy
   );

   modport master (
      output req_valid, req_addr0, req_addr1, req_len0, req_len1, rd_ready, rd_data,
      input  req_ready, rd_req, rd_addr, out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/packet_buffer_read_arbiter.sv
// Round-robin arbiter sharing the packet-buffer BRAM read port between two burst requesters,
// issuing one byte read per cycle and routing returned bytes to their owner.
module packet_buffer_read_arbiter #(
   parameter int unsigned RAM_SIZE     = 64,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned BYTE_LEN     = 8
) (
   input logic                         clk_i,
   input logic                         reset_i,
   packet_buffer_read_arbiter_if.slave bus_io
);
   localparam int unsigned ADDR_W = $clog2(RAM_SIZE);
   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StBurst = 1'b1;
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(RAM_SIZE - 1);
   localparam logic [ADDR_W:0]   LenOne   = (ADDR_W+1)'(1);

   logic [0:0]          state_q, state_d;
   logic                ptr_q, ptr_d;
   logic                owner_q, owner_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [ADDR_W:0]     remaining_q, remaining_d;

   logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [READ_LATENCY-1:0] tag_own_q, tag_own_d;
   logic [READ_LATENCY-1:0] tag_last_q, tag_last_d;

   logic [1:0]          out_valid_q, out_valid_d;
   logic [BYTE_LEN-1:0] out_data_q, out_data_d;
   logic                out_last_q, out_last_d;

   logic                win;
   logic                grant;
   logic [ADDR_W-1:0]   win_addr;
   logic [ADDR_W:0]     win_len;
   logic [1:0]          req_ready;
   logic                rd_req;

   // Prioritised requester wins if valid, otherwise the other one.
   always_comb begin
      win = ptr_q;
      if (!bus_io.req_valid[ptr_q]) begin
         win = ~ptr_q;
      end
      grant     = (state_q == StIdle) && (|bus_io.req_valid);
      win_addr  = win ? bus_io.req_addr1 : bus_io.req_addr0;
      win_len   = win ? bus_io.req_len1 : bus_io.req_len0;
      req_ready = 2'b00;
      if (grant) begin
         req_ready[win] = 1'b1;
      end
      rd_req = (state_q == StBurst);
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      if (grant) begin
         ptr_d       = ~win;
         owner_d     = win;
         cur_addr_d  = win_addr;
         remaining_d = win_len;
         if (win_len != '0) begin
            state_d = StBurst;
         end
      end else if (state_q == StBurst) begin
         cur_addr_d  = (cur_addr_q == LastAddr) ? '0 : cur_addr_q + 1'b1;
         remaining_d = remaining_q - 1'b1;
         if (remaining_q == LenOne) begin
            state_d = StIdle;
         end
      end
   end

   // Tag pipeline mirrors the driver latency so each returned byte finds its owner.
   always_comb begin
      tag_vld_d[0]  = rd_req;
      tag_own_d[0]  = owner_q;
      tag_last_d[0] = (remaining_q == LenOne);
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
         tag_vld_d[i]  = tag_vld_q[i-1];
         tag_own_d[i]  = tag_own_q[i-1];
         tag_last_d[i] = tag_last_q[i-1];
      end
      out_valid_d = 2'b00;
      out_last_d  = 1'b0;
      out_data_d  = out_data_q;
      if (tag_vld_q[READ_LATENCY-1]) begin
         out_valid_d[tag_own_q[READ_LATENCY-1]] = 1'b1;
         out_last_d = tag_last_q[READ_LATENCY-1];
         out_data_d = bus_io.rd_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         ptr_q       <= 1'b0;
         owner_q     <= 1'b0;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         tag_vld_q   <= '0;
         tag_own_q   <= '0;
         tag_last_q  <= '0;
         out_valid_q <= '0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         tag_vld_q   <= tag_vld_d;
         tag_own_q   <= tag_own_d;
         tag_last_q  <= tag_last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus_io.req_ready = req_ready;
   assign bus_io.rd_req    = rd_req;
   assign bus_io.rd_addr   = cur_addr_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_data  = out_data_q;
   assign bus_io.out_last  = out_last_q;
   assign bus_io.busy      = (state_q == StBurst) || (|tag_vld_q) || (|out_valid_q);
endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// Bench for packet_buffer_read_arbiter: BRAM driver model, per-cycle reference model of grants
// and reads, and a scoreboard of expected return bytes checked by a separate monitor.
module tb_packet_buffer_read_arbiter;
   localparam int unsigned RAM_SIZE = 64;
   localparam int unsigned L        = 2;
   localparam int unsigned ADDR_W   = $clog2(RAM_SIZE);

   typedef struct {
      logic [1:0] own;
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   packet_buffer_read_arbiter_if #(.RAM_SIZE(RAM_SIZE), .BYTE_LEN(8)) bus ();

   packet_buffer_read_arbiter #(
      .RAM_SIZE    (RAM_SIZE),
      .READ_LATENCY(L),
      .BYTE_LEN    (8)
   ) dut (
      .clk_i  (clk),
      .reset_i(reset),
      .bus_io (bus)
   );

   logic              rv [2];
   logic [ADDR_W-1:0] ra [2];
   logic [ADDR_W:0]   rl [2];
   logic [7:0]        mem [RAM_SIZE];
   logic              dv [L];
   logic [ADDR_W-1:0] da [L];

   assign bus.req_valid = {rv[1], rv[0]};
   assign bus.req_addr0 = ra[0];
   assign bus.req_addr1 = ra[1];
   assign bus.req_len0  = rl[0];
   assign bus.req_len1  = rl[1];
   assign bus.rd_ready  = dv[L-1];
   assign bus.rd_data   = mem[da[L-1]];

   // BRAM driver: data returns L cycles after rd_req; it is not reset, so old reads drain.
   always @(posedge clk) begin
      dv[0] <= bus.rd_req;
      da[0] <= bus.rd_addr;
      for (int i = 1; i < L; i++) begin
         dv[i] <= dv[i-1];
         da[i] <= da[i-1];
      end
   end

   int   n_checks = 0;
   int   n_fail = 0;
   bit   started = 0;
   exp_t oq[$];
   int   aq[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one burst at a time, reads back-to-back after the grant cycle.
   int cyc = 0;
   int ptr = 0;
   int busy_start = 0;
   int busy_end = -1;
   bit rst_prev = 1;
   always @(negedge clk) begin
      if (started) begin
         int   w;
         int   a0;
         int   len;
         int   ea;
         logic [1:0] exp_ready;
         logic exp_rd;
         exp_t e;
         cyc++;
         if (rst_prev) begin
            aq.delete();
            oq.delete();
            ptr = 0;
            busy_end = -1;
            busy_start = 0;
         end
         check("busy", 32'(bus.busy), 32'(cyc >= busy_start && cyc <= busy_end));
         exp_ready = 2'b00;
         exp_rd = 1'b0;
         ea = 0;
         if (aq.size() > 0) begin
            exp_rd = 1'b1;
            ea = aq.pop_front();
         end else if (bus.req_valid != 2'b00) begin
            w = bus.req_valid[ptr] ? ptr : 1 - ptr;
            exp_ready[w] = 1'b1;
            a0  = (w == 0) ? int'(bus.req_addr0) : int'(bus.req_addr1);
            len = (w == 0) ? int'(bus.req_len0) : int'(bus.req_len1);
            if (!reset) begin
               for (int k = 0; k < len; k++) begin
                  aq.push_back((a0 + k) % RAM_SIZE);
                  e.own  = (w == 0) ? 2'b01 : 2'b10;
                  e.data = mem[(a0 + k) % RAM_SIZE];
                  e.last = (k == len - 1);
                  oq.push_back(e);
               end
               ptr = 1 - w;
               if (len > 0) begin
                  if (cyc + 1 > busy_end + 1) busy_start = cyc + 1;
                  busy_end = cyc + len + L + 1;
               end
            end
         end
         check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
         check("rd_req", 32'(bus.rd_req), 32'(exp_rd));
         if (exp_rd) check("rd_addr", 32'(bus.rd_addr), 32'(ea));
         rst_prev = reset;
      end
   end

   // Monitor: every presented byte must be the next expected one.
   always @(negedge clk) begin
      if (started && bus.out_valid != 2'b00) begin
         exp_t e;
         if (oq.size() == 0) begin
            check("unexpected_out_valid", 32'(bus.out_valid), 32'h0);
         end else begin
            e = oq.pop_front();
            check("out_byte", {21'h0, bus.out_valid, bus.out_data, bus.out_last},
                  {21'h0, e.own, e.data, e.last});
         end
      end
   end

   // Called at cycle start; returns at the start of the cycle after the grant, valid still high.
   task automatic post(input int i, input int a, input int l);
      int n;
      n = 0;
      rv[i] = 1'b1;
      ra[i] = ADDR_W'(a);
      rl[i] = (ADDR_W+1)'(l);
      do begin
         @(negedge clk);
         n++;
      end while (!bus.req_ready[i] && n < 300);
      if (!bus.req_ready[i]) check("grant_timeout", 32'(n), 32'h0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((oq.size() != 0 || aq.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (oq.size() != 0 || aq.size() != 0) check("drain_timeout", 32'(oq.size()), 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < RAM_SIZE; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < L; i++) begin
         dv[i] = 1'b0;
         da[i] = '0;
      end
      for (int i = 0; i < 2; i++) begin
         rv[i] = 1'b0;
         ra[i] = '0;
         rl[i] = '0;
      end
      idle(3);
      reset = 1'b0;
      started = 1;
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_rd_req", 32'(bus.rd_req), 32'h0);
      check("rst_out", {22'h0, bus.out_valid, bus.out_data}, 32'h0);
      check("rst_out_last", 32'(bus.out_last), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      @(posedge clk);
      #1;

      post(0, 5, 3);
      rv[0] = 1'b0;
      drain();

      fork
         begin post(0, 10, 2); rv[0] = 1'b0; end
         begin post(1, 20, 2); rv[1] = 1'b0; end
      join
      drain();

      post(1, RAM_SIZE - 2, 4);
      rv[1] = 1'b0;
      drain();

      fork
         begin post(0, 7, 0); rv[0] = 1'b0; end
         begin post(1, 30, 2); rv[1] = 1'b0; end
      join
      drain();

      post(0, 9, RAM_SIZE);
      rv[0] = 1'b0;
      drain();

      fork
         begin repeat (4) post(0, 40, 1); rv[0] = 1'b0; end
         begin repeat (4) post(1, 50, 1); rv[1] = 1'b0; end
      join
      drain();

      // Reset two cycles into a 10-byte burst.
      post(0, 12, 10);
      rv[0] = 1'b0;
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      @(negedge clk);
      check("busy_after_reset", 32'(bus.busy), 32'h0);
      idle(L + 4);

      fork
         for (int k = 0; k < 12; k++) begin
            idle($urandom_range(0, 3));
            post(0, $urandom_range(0, RAM_SIZE - 1), ($urandom_range(0, 9) == 0) ? 0 :
                 $urandom_range(1, 6));
            rv[0] = 1'b0;
         end
         for (int k = 0; k < 12; k++) begin
            idle($urandom_range(0, 3));
            post(1, $urandom_range(0, RAM_SIZE - 1), ($urandom_range(0, 9) == 0) ? 0 :
                 $urandom_range(1, 6));
            rv[1] = 1'b0;
         end
      join
      drain();
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
